seg7_scan_decoder: RTL

Reads back a time-multiplexed, active-low 7-segment display bus (anodes plus shared segments) and recovers the hex digit shown on each position. It is the inverse of the team's hex-to-segment encoder. It sits in the score/debug display path as an on-chip monitor so benches and self-checks can compare the displayed value with the intended one. Inputs are synchronized, each anode dwell is debounced, and every captured segment pattern is decoded against the encoder's exact table.

---
 rtl/seg7_scan_decoder.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/seg7_scan_decoder.sv
// Monitors a multiplexed active-low 7-segment bus and recovers the hex digit on each position.
// Each single-anode dwell is debounced, then decoded against the encoder's segment table.
module seg7_scan_decoder #(
    parameter int DIGITS        = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DIGITS-1:0]     an,
    input  logic [6:0]            seg,
    input  logic                  err_clr,
    output logic [4*DIGITS-1:0]   digits,
    output logic [DIGITS-1:0]     digit_valid,
    output logic                  frame_done,
    output logic [1:0]            err
);

    typedef enum logic [1:0] {ST_BLANK, ST_SETTLE, ST_HELD, ST_ERRM} state_t;

    // Returns {valid, blank, value}; anything else decodes to all zeros (invalid).
    function automatic logic [5:0] f_decode(input logic [6:0] s);
        case (s)
            7'h40: return {2'b10, 4'h0};
            7'h79: return {2'b10, 4'h1};
            7'h24: return {2'b10, 4'h2};
            7'h30: return {2'b10, 4'h3};
            7'h19: return {2'b10, 4'h4};
            7'h12: return {2'b10, 4'h5};
            7'h02: return {2'b10, 4'h6};
            7'h78: return {2'b10, 4'h7};
            7'h00: return {2'b10, 4'h8};
            7'h18: return {2'b10, 4'h9};
            7'h08: return {2'b10, 4'hA};
            7'h03: return {2'b10, 4'hB};
            7'h46: return {2'b10, 4'hC};
            7'h21: return {2'b10, 4'hD};
            7'h06: return {2'b10, 4'hE};
            7'h0E: return {2'b10, 4'hF};
            7'h7F: return {2'b01, 4'h0};
            default: return 6'b00_0000;
        endcase
    endfunction

    logic [DIGITS-1:0]   r_an_s1, r_an_s2, r_an_prev;
    logic [6:0]          r_seg_s1, r_seg_s2, r_seg_prev;
    state_t              r_state, w_state_nxt;
    logic [7:0]          r_cnt, w_cnt_nxt;
    logic [DIGITS-1:0]   r_mask, w_mask_nxt;
    logic [4*DIGITS-1:0] r_digits;
    logic [DIGITS-1:0]   r_valid;
    logic                r_frame_done;
    logic [1:0]          r_err, w_err_set;
    logic [DIGITS-1:0]   w_an_act;
    logic                w_none, w_multi, w_changed, w_capture, w_errm_entry;
    logic [5:0]          w_dec;

    // Input synchronizers; reset to an idle (blank) bus so no change is seen after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_an_s1    <= '1;
            r_an_s2    <= '1;
            r_an_prev  <= '1;
            r_seg_s1   <= '1;
            r_seg_s2   <= '1;
            r_seg_prev <= '1;
        end else begin
            r_an_s1    <= an;
            r_an_s2    <= r_an_s1;
            r_an_prev  <= r_an_s2;
            r_seg_s1   <= seg;
            r_seg_s2   <= r_seg_s1;
            r_seg_prev <= r_seg_s2;
        end
    end

    always_comb begin
        w_an_act  = ~r_an_s2;
        w_none    = (w_an_act == '0);
        w_multi   = !w_none && ((w_an_act & (w_an_act - DIGITS'(1))) != '0);
        w_changed = ({r_an_s2, r_seg_s2} != {r_an_prev, r_seg_prev});
    end

    // Next-state / stability counter
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_capture    = 1'b0;
        w_errm_entry = 1'b0;
        if (w_changed) begin
            if (w_none) begin
                w_state_nxt = ST_BLANK;
                w_cnt_nxt   = 8'd0;
            end else if (w_multi) begin
                w_state_nxt  = ST_ERRM;
                w_cnt_nxt    = 8'd0;
                w_errm_entry = 1'b1;
            end else begin
                w_state_nxt = ST_SETTLE;
                w_cnt_nxt   = 8'd1;
            end
        end else begin
            case (r_state)
                ST_BLANK, ST_ERRM: w_cnt_nxt = 8'd0;
                default: begin
                    w_cnt_nxt = (r_cnt == 8'hFF) ? r_cnt : r_cnt + 8'd1;
                    if (r_state == ST_SETTLE && w_cnt_nxt == 8'(STABLE_CYCLES)) begin
                        w_state_nxt = ST_HELD;
                        w_capture   = 1'b1;
                    end
                end
            endcase
        end
    end

    // Decode and frame bookkeeping; a full mask clears on the cycle frame_done fires.
    always_comb begin
        w_dec      = f_decode(r_seg_s2);
        w_mask_nxt = (&r_mask) ? '0 : r_mask;
        if (w_capture && (w_dec[5] || w_dec[4]))
            w_mask_nxt = w_mask_nxt | w_an_act;
        w_err_set    = 2'b00;
        w_err_set[1] = w_errm_entry;
        w_err_set[0] = w_capture && !w_dec[5] && !w_dec[4];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_BLANK;
            r_cnt        <= 8'd0;
            r_mask       <= '0;
            r_digits     <= '0;
            r_valid      <= '0;
            r_frame_done <= 1'b0;
            r_err        <= 2'b00;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_mask       <= w_mask_nxt;
            r_frame_done <= &r_mask;
            r_err        <= (r_err & ~{2{err_clr}}) | w_err_set;
            for (int k = 0; k < DIGITS; k++) begin
                if (w_capture && w_an_act[k]) begin
                    if (w_dec[5])
                        r_digits[4*k +: 4] <= w_dec[3:0];
                    r_valid[k] <= w_dec[5];
                end
            end
        end
    end

    assign digits      = r_digits;
    assign digit_valid = r_valid;
    assign frame_done  = r_frame_done;
    assign err         = r_err;

endmodule
